// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl_if
// Brief   : ID-stage decode inputs and pipeline control outputs of the hazard unit
// Revision: 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int STAGES = 5,
  parameter int REG_W  = 5
);
  logic              fetch_valid;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rs2;
  logic              id_uses_rs;
  logic              id_uses_rs2;
  logic [REG_W-1:0]  id_rd;
  logic              id_reg_wr;
  logic              id_is_load;
  logic              id_is_mul;
  logic              id_is_branch;
  logic              id_branch_taken;
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_en;
  logic              pc_en;
  logic              bubble;
  logic              flush_ifid;
  logic              mul_busy;
  logic [15:0]       stall_cycles;

  modport master (
    output fetch_valid, id_rs, id_rs2, id_uses_rs, id_uses_rs2, id_rd,
           id_reg_wr, id_is_load, id_is_mul, id_is_branch, id_branch_taken,
    input  stage_valid, stage_en, pc_en, bubble, flush_ifid, mul_busy,
           stall_cycles
  );

  modport slave (
    input  fetch_valid, id_rs, id_rs2, id_uses_rs, id_uses_rs2, id_rd,
           id_reg_wr, id_is_load, id_is_mul, id_is_branch, id_branch_taken,
    output stage_valid, stage_en, pc_en, bubble, flush_ifid, mul_busy,
           stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Valid tracking, load-use/branch hazard stall, branch squash and
//           multiply freeze for an in-order pipeline of STAGES registers
// Revision: 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int STAGES     = 5,
  parameter int REG_W      = 5,
  parameter int MUL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int              CNT_W    = 8;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]  mul_cnt_q, mul_cnt_d;
  logic [15:0]       stall_q, stall_d;
  logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
  logic              ex_reg_wr_q, ex_reg_wr_d;
  logic              ex_is_load_q, ex_is_load_d;

  logic              id_valid, dep, hazard, branch, busy;
  logic [STAGES-1:0] en;
  logic              pc_en, bubble, flush;

  always_comb begin
    id_valid = valid_q[0];
    busy     = (mul_cnt_q != '0);
    dep      = ex_reg_wr_q & valid_q[1] & (ex_rd_q != '0) &
               ((bus.id_uses_rs  & (bus.id_rs  == ex_rd_q)) |
                (bus.id_uses_rs2 & (bus.id_rs2 == ex_rd_q)));
    hazard   = id_valid & dep & (ex_is_load_q | bus.id_is_branch);
    branch   = id_valid & bus.id_branch_taken & bus.id_is_branch;
  end

  // Priority: multiply freeze, then data hazard, then taken-branch squash.
  always_comb begin
    en      = '1;
    pc_en   = 1'b1;
    bubble  = 1'b0;
    flush   = 1'b0;
    valid_d = {valid_q[STAGES-2:0], bus.fetch_valid};
    if (busy) begin
      en      = '0;
      pc_en   = 1'b0;
      valid_d = valid_q;
    end else if (hazard) begin
      pc_en      = 1'b0;
      en[0]      = 1'b0;
      bubble     = 1'b1;
      valid_d[0] = valid_q[0];
      valid_d[1] = 1'b0;
    end else if (branch) begin
      flush      = 1'b1;
      valid_d[0] = 1'b0;
    end
  end

  always_comb begin
    ex_rd_d      = ex_rd_q;
    ex_reg_wr_d  = ex_reg_wr_q;
    ex_is_load_d = ex_is_load_q;
    mul_cnt_d    = mul_cnt_q;
    if (bubble) begin
      ex_rd_d      = '0;
      ex_reg_wr_d  = 1'b0;
      ex_is_load_d = 1'b0;
    end else if (en[1]) begin
      ex_rd_d      = bus.id_rd;
      ex_reg_wr_d  = bus.id_reg_wr;
      ex_is_load_d = bus.id_is_load;
    end
    if (busy)
      mul_cnt_d = mul_cnt_q - 1'b1;
    else if (en[1] && !bubble && id_valid && bus.id_is_mul)
      mul_cnt_d = MUL_LOAD;
    stall_d = (!pc_en && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= '0;
      mul_cnt_q    <= '0;
      stall_q      <= '0;
      ex_rd_q      <= '0;
      ex_reg_wr_q  <= 1'b0;
      ex_is_load_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      mul_cnt_q    <= mul_cnt_d;
      stall_q      <= stall_d;
      ex_rd_q      <= ex_rd_d;
      ex_reg_wr_q  <= ex_reg_wr_d;
      ex_is_load_q <= ex_is_load_d;
    end
  end

  assign bus.stage_valid  = valid_q;
  assign bus.stage_en     = en;
  assign bus.pc_en        = pc_en;
  assign bus.bubble       = bubble;
  assign bus.flush_ifid   = flush;
  assign bus.mul_busy     = busy;
  assign bus.stall_cycles = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Directed vector table, async-reset corner and randomized run
//           against an instruction-slot model of the pipeline
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
  localparam int STAGES     = 5;
  localparam int REG_W      = 5;
  localparam int MUL_CYCLES = 4;
  localparam int NVEC       = 21;
  localparam int NRAND      = 3000;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.STAGES(STAGES), .REG_W(REG_W)) bus ();

  pipe_hazard_ctrl #(.STAGES(STAGES), .REG_W(REG_W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic fv; logic [REG_W-1:0] rs; logic ur; logic [REG_W-1:0] rs2; logic ur2;
    logic [REG_W-1:0] rd; logic wr, ld, mul, br, tk;
    logic pc; logic [STAGES-1:0] en; logic bub, fl, busy;
    logic [STAGES-1:0] sv; logic [15:0] stall;
  } vec_t;

  function automatic vec_t v(input logic fv, input logic [4:0] rs, input logic ur,
                             input logic [4:0] rs2, input logic ur2, input logic [4:0] rd,
                             input logic wr, input logic ld, input logic mul,
                             input logic br, input logic tk, input logic pc,
                             input logic [4:0] en, input logic bub, input logic fl,
                             input logic busy, input logic [4:0] sv, input int stall);
    vec_t r;
    r.fv = fv; r.rs = rs; r.ur = ur; r.rs2 = rs2; r.ur2 = ur2; r.rd = rd;
    r.wr = wr; r.ld = ld; r.mul = mul; r.br = br; r.tk = tk;
    r.pc = pc; r.en = en; r.bub = bub; r.fl = fl; r.busy = busy;
    r.sv = sv; r.stall = 16'(stall);
    return r;
  endfunction

  task automatic drive(input logic fv, input logic [REG_W-1:0] rs, input logic ur,
                       input logic [REG_W-1:0] rs2, input logic ur2, input logic [REG_W-1:0] rd,
                       input logic wr, input logic ld, input logic mul,
                       input logic br, input logic tk);
    bus.fetch_valid = fv;  bus.id_rs = rs;   bus.id_uses_rs = ur;
    bus.id_rs2 = rs2;      bus.id_uses_rs2 = ur2;
    bus.id_rd = rd;        bus.id_reg_wr = wr; bus.id_is_load = ld;
    bus.id_is_mul = mul;   bus.id_is_branch = br; bus.id_branch_taken = tk;
  endtask

  // One slot per pipeline register; slot 1 carries the EX instruction's write info.
  typedef struct { bit v; int rd; bit wr; bit ld; } slot_t;
  slot_t pipe[STAGES];
  int    m_freeze;
  int    m_stall;

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) pipe[k] = '{0, 0, 0, 0};
    m_freeze = 0;
    m_stall  = 0;
  endtask

  function automatic logic [STAGES-1:0] model_valid();
    logic [STAGES-1:0] r;
    for (int k = 0; k < STAGES; k++) r[k] = pipe[k].v;
    return r;
  endfunction

  vec_t tbl[NVEC];

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // fv rs ur rs2 ur2 rd wr ld mul br tk | pc en bub fl busy | sv stall
    tbl[0]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 5'b00001, 0);
    tbl[1]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 5'b00011, 0);
    tbl[2]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 5'b00111, 0);
    tbl[3]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 5'b01111, 0);
    tbl[4]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 5'b11111, 0);
    tbl[5]  = v(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 5'b11111, 0);
    tbl[6]  = v(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 5'b11110, 1, 0, 0, 5'b11101, 1);
    tbl[7]  = v(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 5'b11011, 1);
    tbl[8]  = v(1, 4, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 5'b10111, 1);
    tbl[9]  = v(1, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 5'b01111, 1);
    tbl[10] = v(1, 5, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 5'b11111, 1);
    tbl[11] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5'b11111, 0, 1, 0, 5'b11110, 1);
    tbl[12] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 5'b11101, 1);
    tbl[13] = v(1, 0, 0, 0, 0, 6, 1, 0, 1, 0, 0, 1, 5'b11111, 0, 0, 0, 5'b11011, 1);
    tbl[14] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 1, 5'b11011, 2);
    tbl[15] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 1, 5'b11011, 3);
    tbl[16] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 1, 5'b11011, 4);
    tbl[17] = v(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 5'b10111, 4);
    tbl[18] = v(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b11110, 1, 0, 0, 5'b01101, 5);
    tbl[19] = v(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5'b11111, 0, 1, 0, 5'b11010, 5);
    tbl[20] = v(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5'b11111, 0, 0, 0, 5'b10101, 5);

    #1;
    check("rst_valid",  32'(bus.stage_valid), 32'(0));
    check("rst_stall",  32'(bus.stall_cycles), 32'(0));
    check("rst_busy",   32'(bus.mul_busy), 32'(0));
    check("rst_pc_en",  32'(bus.pc_en), 32'(1));
    check("rst_en",     32'(bus.stage_en), 32'(5'b11111));
    check("rst_bubble", 32'(bus.bubble), 32'(0));
    check("rst_flush",  32'(bus.flush_ifid), 32'(0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(tbl[i].fv, tbl[i].rs, tbl[i].ur, tbl[i].rs2, tbl[i].ur2, tbl[i].rd,
            tbl[i].wr, tbl[i].ld, tbl[i].mul, tbl[i].br, tbl[i].tk);
      #1;
      check($sformatf("vec%0d_pc_en", i),  32'(bus.pc_en), 32'(tbl[i].pc));
      check($sformatf("vec%0d_en", i),     32'(bus.stage_en), 32'(tbl[i].en));
      check($sformatf("vec%0d_bubble", i), 32'(bus.bubble), 32'(tbl[i].bub));
      check($sformatf("vec%0d_flush", i),  32'(bus.flush_ifid), 32'(tbl[i].fl));
      check($sformatf("vec%0d_busy", i),   32'(bus.mul_busy), 32'(tbl[i].busy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i),  32'(bus.stage_valid), 32'(tbl[i].sv));
      check($sformatf("vec%0d_stall", i),  32'(bus.stall_cycles), 32'(tbl[i].stall));
    end

    // Asynchronous reset two cycles into a multiply freeze.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check("mfrz_busy_start", 32'(bus.mul_busy), 32'(1));
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("mfrz_busy_cnt2", 32'(bus.mul_busy), 32'(1));
    check("mfrz_stall",     32'(bus.stall_cycles), 32'(6));
    check("mfrz_valid",     32'(bus.stage_valid), 32'(5'b01011));
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy",  32'(bus.mul_busy), 32'(0));
    check("arst_valid", 32'(bus.stage_valid), 32'(0));
    check("arst_stall", 32'(bus.stall_cycles), 32'(0));
    check("arst_pc_en", 32'(bus.pc_en), 32'(1));
    check("arst_en",    32'(bus.stage_en), 32'(5'b11111));

    // Randomized run against the slot model.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < NRAND; i++) begin
      bit frz, haz, brn, dep, e_pc;
      logic [STAGES-1:0] e_en;
      slot_t ex;
      @(negedge clk);
      drive($urandom_range(0, 3) != 0,
            REG_W'($urandom_range(0, 3)), 1'($urandom),
            REG_W'($urandom_range(0, 3)), 1'($urandom),
            REG_W'($urandom_range(0, 3)), 1'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0, 1'($urandom));
      ex   = pipe[1];
      dep  = ex.v && ex.wr && ex.rd != 0 &&
             ((bus.id_uses_rs  && int'(bus.id_rs)  == ex.rd) ||
              (bus.id_uses_rs2 && int'(bus.id_rs2) == ex.rd));
      frz  = (m_freeze > 0);
      haz  = !frz && pipe[0].v && dep && (ex.ld || bus.id_is_branch);
      brn  = !frz && !haz && pipe[0].v && bus.id_is_branch && bus.id_branch_taken;
      e_pc = !(frz || haz);
      e_en = frz ? '0 : (haz ? {{(STAGES-1){1'b1}}, 1'b0} : '1);
      #1;
      check("rnd_pc_en",  32'(bus.pc_en), 32'(e_pc));
      check("rnd_en",     32'(bus.stage_en), 32'(e_en));
      check("rnd_bubble", 32'(bus.bubble), 32'(haz));
      check("rnd_flush",  32'(bus.flush_ifid), 32'(brn));
      check("rnd_busy",   32'(bus.mul_busy), 32'(frz));
      if (frz) begin
        m_freeze--;
      end else begin
        for (int k = STAGES - 1; k >= 2; k--) pipe[k] = pipe[k-1];
        if (haz) begin
          pipe[1] = '{0, 0, 0, 0};
        end else begin
          pipe[1] = '{pipe[0].v, int'(bus.id_rd), bus.id_reg_wr, bus.id_is_load};
          if (pipe[0].v && bus.id_is_mul) m_freeze = MUL_CYCLES - 1;
          pipe[0].v = brn ? 1'b0 : bus.fetch_valid;
        end
      end
      if (!e_pc && m_stall < 16'hFFFF) m_stall++;
      @(posedge clk);
      #1;
      check("rnd_valid", 32'(bus.stage_valid), 32'(model_valid()));
      check("rnd_stall", 32'(bus.stall_cycles), 32'(m_stall));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
